lane_unpacking: RTL
===================

LANE_UNPACKING -- requirements
Module: lane_unpacking

Interface
REQ-001 SHALL have parameter LANE_IN, default 4, number of input lanes per word.
REQ-002 SHALL have parameter LANE_OUT, default 1, number of output lanes per beat; LANE_IN SHALL be an integer multiple of LANE_OUT (elaboration error otherwise).
REQ-003 SHALL have parameter WIDTH, default 16, bits per lane element.
REQ-004 SHALL have port clk input 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n input 1, reset, synchronous and active-low.
REQ-006 SHALL have port s_valid input 1, input word present.
REQ-007 SHALL have port s_ready output 1, input word accepted when s_valid && s_ready.
REQ-008 SHALL have port s_data_vd input LANE_IN, per-lane valid mask of the input word (any pattern).
REQ-009 SHALL have port s_data input WIDTH x LANE_IN unpacked array, input lane elements.
REQ-010 SHALL have port m_ready input 1, downstream accepts the current output beat.
REQ-011 SHALL have port m_data_vd output LANE_OUT, output valid mask; beat is valid when any bit is set.
REQ-012 SHALL have port m_data output WIDTH x LANE_OUT unpacked array, output elements.

Function
REQ-013 SHALL, on word acceptance, store only lanes with s_data_vd set, in ascending lane-index order; invalid lanes are discarded.
REQ-014 SHALL emit stored elements in that order, LANE_OUT per beat, with the earliest element on output lane 0.
REQ-015 SHALL emit a final partial beat when the remaining count is below LANE_OUT: mask low-aligned (e.g. 2'b01); unused lanes are don't-care.
REQ-016 SHALL implement two states: IDLE (buffer empty) and DRAIN (remaining count > 0). IDLE->DRAIN on acceptance of a non-empty word. DRAIN->IDLE when the last beat is accepted with no new word. DRAIN->DRAIN when the last beat and a new non-empty word are accepted in the same cycle.
REQ-017 SHALL drive s_ready = IDLE || (last beat pending && m_ready), giving back-to-back words with no bubble.
REQ-018 SHALL register the outputs: the first beat of an accepted word appears the cycle after acceptance; latency is 1 cycle.
REQ-019 SHALL hold m_data_vd and m_data stable while m_data_vd != 0 && !m_ready.
REQ-020 SHALL accept and drop a word with s_data_vd == 0, with no output beat and no state change.
REQ-021 SHALL track the remaining count with a $clog2(LANE_IN+1)-bit counter, decremented by min(remaining, LANE_OUT) per accepted beat, and never underflow.
REQ-022 SHALL pass s_data_vd to m_data_vd and s_data to m_data combinationally when LANE_IN == LANE_OUT, with s_ready = m_ready.

Reset
REQ-023 SHALL, while rst_n == 0 at a clock edge: m_data_vd = 0, s_ready = 0, state = IDLE, count = 0; m_data is don't-care.
REQ-024 SHALL, if rst_n is asserted mid-DRAIN, discard buffered elements with no further beats.
REQ-025 SHALL drive s_ready high the first cycle after rst_n deasserts.

Configuration
REQ-026 SHALL, with macro LANE_UNPACKING_COUNT_EN defined, add output port elem_count (32 bits): reset 0, incremented by popcount(m_data_vd) on each accepted beat, wrapping modulo 2^32.
REQ-027 SHALL, without LANE_UNPACKING_COUNT_EN, have no elem_count port or logic, and behaviour is otherwise identical.

Structure
REQ-028 SHALL place the state enum (IDLE, DRAIN) and a popcount function in shared package lane_pkg.
REQ-029 SHALL use sub-module lane_compact, a combinational mask-driven compactor producing a low-aligned element array and a count, to fill the buffer.

Verification
REQ-030 SHALL cover: LANE_IN=4, LANE_OUT=1, word mask 4'b1111 data {D,C,B,A} (lane3..0), m_ready=1 -> beats A,B,C,D on 4 consecutive cycles starting 1 cycle after acceptance; s_ready high in the D cycle.
REQ-031 SHALL cover: mask 4'b1010 data {D,C,B,A} -> beats B then D; A and C never appear.
REQ-032 SHALL cover: LANE_OUT=2, mask 4'b0111 -> beat {B,A} mask 2'b11, then {x,C} mask 2'b01.
REQ-033 SHALL cover: mask 4'b0000 accepted -> no beat; the next word 4'b0001 (A) -> A 1 cycle later.
REQ-034 SHALL cover: m_ready low for 3 cycles mid-DRAIN -> output held stable, s_ready low, no element lost or duplicated.
REQ-035 SHALL cover: rst_n low for 1 cycle after 2 of 4 elements -> no further beats; m_data_vd=0; s_ready=1 the following cycle; with LANE_UNPACKING_COUNT_EN, elem_count=0.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared types and helpers for the lane unpacker: FSM state encoding and a popcount.
`default_nettype none

package lane_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_compact.sv
// Combinational compactor: gathers mask-selected lanes into a low-aligned array plus a count.
`default_nettype none

module lane_compact #(
  parameter int LANES = 4,
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] mask,
  input  logic [WIDTH-1:0] data  [LANES],
  output logic [WIDTH-1:0] comp  [LANES],
  output logic [CNT_W-1:0] count
);

  // Slot k receives the selected lane whose lower-index selected-lane count equals k.
  always_comb begin
    int prefix;
    prefix = 0;
    for (int k = 0; k < LANES; k++) comp[k] = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        for (int k = 0; k < LANES; k++) begin
          if (prefix == k) comp[k] = data[i];
        end
        prefix++;
      end
    end
    count = CNT_W'(prefix);
  end

endmodule

`default_nettype wire

// File: rtl/lane_unpacking.sv
// Unpacks sparse LANE_IN-lane words into LANE_OUT-lane beats in lane order.
// Optional macro LANE_UNPACKING_COUNT_EN adds a 32-bit elem_count output.
`default_nettype none

module lane_unpacking
  import lane_pkg::*;
#(
  parameter int LANE_IN  = 4,
  parameter int LANE_OUT = 1,
  parameter int WIDTH    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [LANE_IN-1:0]  s_data_vd,
  input  logic [WIDTH-1:0]    s_data    [LANE_IN],
  input  logic                m_ready,
  output logic [LANE_OUT-1:0] m_data_vd,
  output logic [WIDTH-1:0]    m_data    [LANE_OUT]
`ifdef LANE_UNPACKING_COUNT_EN
  ,
  output logic [31:0]         elem_count
`endif
);

  localparam int CW = $clog2(LANE_IN + 1);

  if (LANE_OUT < 1 || (LANE_IN % LANE_OUT) != 0) begin : g_bad_ratio
    $error("lane_unpacking: LANE_IN must be an integer multiple of LANE_OUT");
  end

  if (LANE_IN == LANE_OUT) begin : g_pass
    assign s_ready   = rst_n && m_ready;
    assign m_data_vd = (rst_n && s_valid) ? s_data_vd : '0;
    assign m_data    = s_data;
  end else begin : g_unpack
    localparam logic [CW-1:0] OUT_N = CW'(LANE_OUT);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     buffer [LANE_IN];
    logic [LANE_OUT-1:0]  vd;
    logic [WIDTH-1:0]     comp   [LANE_IN];
    logic [CW-1:0]        comp_cnt;
    logic [CW-1:0]        step;
    logic                 last;
    logic                 s_fire;
    logic                 beat_fire;
    logic                 load;

    function automatic logic [LANE_OUT-1:0] low_mask(input logic [CW-1:0] n);
      logic [LANE_OUT-1:0] m;
      m = '0;
      for (int j = 0; j < LANE_OUT; j++) m[j] = (j < int'(n));
      return m;
    endfunction

    lane_compact #(
      .LANES (LANE_IN),
      .WIDTH (WIDTH),
      .CNT_W (CW)
    ) u_compact (
      .mask  (s_data_vd),
      .data  (s_data),
      .comp  (comp),
      .count (comp_cnt)
    );

    assign last      = (state == DRAIN) && (cnt <= OUT_N);
    assign step      = (cnt < OUT_N) ? cnt : OUT_N;
    assign s_ready   = rst_n && ((state == IDLE) || (last && m_ready));
    assign s_fire    = s_valid && s_ready;
    assign beat_fire = (state == DRAIN) && m_ready;
    // A word can only be taken in IDLE or alongside the final beat, so load wins.
    assign load      = s_fire && (comp_cnt != '0);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state <= IDLE;
        cnt   <= '0;
        vd    <= '0;
      end else if (load) begin
        buffer <= comp;
        cnt    <= comp_cnt;
        vd     <= low_mask(comp_cnt);
        state  <= DRAIN;
      end else if (beat_fire) begin
        if (last) begin
          cnt   <= '0;
          vd    <= '0;
          state <= IDLE;
        end else begin
          for (int i = 0; i < LANE_IN - LANE_OUT; i++) buffer[i] <= buffer[i + LANE_OUT];
          cnt <= cnt - step;
          vd  <= low_mask(cnt - step);
        end
      end
    end

    assign m_data_vd = vd;
    always_comb begin
      for (int j = 0; j < LANE_OUT; j++) m_data[j] = buffer[j];
    end
  end

`ifdef LANE_UNPACKING_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      elem_count <= '0;
    end else if (m_ready && (m_data_vd != '0)) begin
      elem_count <= elem_count + popcount(32'(m_data_vd));
    end
  end
`endif

endmodule

`default_nettype wire
